cl_serial_seq: RTL



---
 rtl/cl_pkg.sv | 36 +++
 rtl/cl_serial_seq_shift_reg_n.sv | 45 ++++
 rtl/cl_serial_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cl_pkg.sv
// ============================================================================
// Module   : cl_pkg
// Purpose  : Shared constants and helpers for the bit-serial logic-cell
//            sequencer (operation codes, FSM encoding, default width,
//            counter-width helper).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cl_pkg;

  // Operation select presented to the single-bit logic cell.
  typedef logic [1:0] cl_op_t;

  localparam cl_op_t OP_AND = 2'b00;
  localparam cl_op_t OP_OR  = 2'b01;
  localparam cl_op_t OP_XOR = 2'b10;
  localparam cl_op_t OP_NOT = 2'b11;

  // Sequencer FSM encoding.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // Default operand/result width.
  localparam int CL_N = 8;

  // Bit counter width: enough to count 0 .. n-1.
  function automatic int cl_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : cl_pkg

`default_nettype wire

// File: rtl/cl_serial_seq_shift_reg_n.sv
// ============================================================================
// Module   : shift_reg_n
// Purpose  : N-bit right-shifting register with parallel load, shift enable
//            and serial input entering at the MSB. Load has priority over
//            shift.
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous active-high reset (clears to 0)
//            load     - parallel load strobe
//            load_val - parallel load value
//            shift_en - shift right by one, sin enters at bit N-1
//            sin      - serial input
//            q        - register contents
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_reg_n #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         shift_en,
  input  logic         sin,
  output logic [N-1:0] q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (shift_en) begin
      r_q <= {sin, r_q[N-1:1]};
    end
  end

  assign q = r_q;

endmodule : shift_reg_n

`default_nettype wire

// File: rtl/cl_serial_seq.sv
// ============================================================================
// Module   : cl_serial_seq
// Purpose  : Bit-serial sequencer for a single-bit combinational logic cell.
//            Latches two N-bit operands and an operation on start, presents
//            one bit pair per cycle (LSB first) to the cell and shifts the
//            cell's result bit into an N-bit result register. Completion is
//            signalled by a one-cycle done pulse.
// Options  : `define CL_SEQ_PARITY_EN adds a parity output equal to the XOR
//            of all result bits (valid with done, held until next start).
// Ports    : clk    - clock, rising edge
//            reset  - asynchronous active-high reset
//            start  - request pulse (accepted in IDLE, or in DONE for
//                     back-to-back operation)
//            op     - 00 AND, 01 OR, 10 XOR, 11 NOT a
//            opa    - operand A
//            opb    - operand B
//            cl_a   - A bit to the logic cell
//            cl_b   - B bit to the logic cell
//            cl_s   - operation select to the logic cell
//            cl_out - combinational result bit from the logic cell
//            busy   - high in RUN and DONE
//            done   - one-cycle completion pulse
//            result - assembled result, held until next accepted start
//            zero   - result == 0, valid with done, held with result
//            parity - (CL_SEQ_PARITY_EN only) XOR of result bits
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cl_serial_seq
  import cl_pkg::*;
#(
  parameter int N = CL_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] opa,
  input  logic [N-1:0] opb,
  output logic         cl_a,
  output logic         cl_b,
  output logic [1:0]   cl_s,
  input  logic         cl_out,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero
`ifdef CL_SEQ_PARITY_EN
  ,
  output logic         parity
`endif
);

  localparam int             CW         = cl_cnt_width(N);
  localparam logic [CW-1:0]  c_last_cnt = CW'(N - 1);
  localparam logic [CW-1:0]  c_cnt_one  = CW'(1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  cl_op_t        r_sop;
  logic          r_zero;

  logic [N-1:0]  w_sa_q;
  logic [N-1:0]  w_sb_q;
  logic [N-1:0]  w_res_q;
  logic [N-1:0]  w_res_next;
  logic          w_run;
  logic          w_last;
  logic          w_accept;

  assign w_run  = (r_state == S_RUN);
  assign w_last = w_run && (r_cnt == c_last_cnt);

  // A new request is taken in IDLE and also in DONE: accepting in DONE is
  // what gives one operation per N+1 cycles when start is held high.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Value the result register takes at this edge while running; used to
  // resolve the zero flag on the final capture edge.
  assign w_res_next = {cl_out, w_res_q[N-1:1]};

  // --------------------------------------------------------------------------
  // FSM and bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sop   <= OP_AND;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_sop   <= op;
            r_zero  <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + c_cnt_one;
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_zero  <= (w_res_next == '0);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Operand and result shift registers
  // --------------------------------------------------------------------------
  shift_reg_n #(.N(N)) u_sa (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .load_val (opa),
    .shift_en (w_run),
    .sin      (1'b0),
    .q        (w_sa_q)
  );

  shift_reg_n #(.N(N)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .load_val (opb),
    .shift_en (w_run),
    .sin      (1'b0),
    .q        (w_sb_q)
  );

  // Result is cleared on an accepted start and fills from the MSB end, so
  // after N captures bit i holds the cell output for operand bit i.
  shift_reg_n #(.N(N)) u_res (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .load_val ({N{1'b0}}),
    .shift_en (w_run),
    .sin      (cl_out),
    .q        (w_res_q)
  );

  // Only bit 0 of each operand register feeds the cell.
  logic w_unused;
  assign w_unused = ^{w_sa_q[N-1:1], w_sb_q[N-1:1]};

  // --------------------------------------------------------------------------
  // Optional parity accumulator
  // --------------------------------------------------------------------------
`ifdef CL_SEQ_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= 1'b0;
    end else if (w_run) begin
      r_parity <= r_parity ^ cl_out;
    end
  end

  assign parity = r_parity;
`endif

  // --------------------------------------------------------------------------
  // Outputs: cell drive is gated to 0 outside RUN; all sources are flops so
  // the cell inputs are stable for the whole cycle.
  // --------------------------------------------------------------------------
  assign cl_a   = w_run & w_sa_q[0];
  assign cl_b   = w_run & w_sb_q[0];
  assign cl_s   = w_run ? r_sop : 2'b00;
  assign busy   = (r_state == S_RUN) || (r_state == S_DONE);
  assign done   = (r_state == S_DONE);
  assign result = w_res_q;
  assign zero   = r_zero;

endmodule : cl_serial_seq

`default_nettype wire
